flag_reg_stack: RTL

Parametrised successor to the CPU flag register: holds `FLAG_W` status flags (default C/Z/B) updated from the ALU under a per-bit write mask, and adds explicit set/clear control. It also adds a `DEPTH`-entry hardware save/restore stack used on call/interrupt entry and return. It sits between the ALU flag outputs and the control unit/branch logic; all outputs are registered.

---
 rtl/flag_reg_stack.sv | 107 ++++++++++
 1 files changed

// File: rtl/flag_reg_stack.sv
`default_nettype none
// ============================================================================
//  Module   : flag_reg_stack
//  Purpose  : Status flag register with masked ALU update, explicit set/clear
//             and a LIFO save/restore stack for call/interrupt nesting.
//  Revision : 1.0  initial release
// ============================================================================
module flag_reg_stack #(
    parameter int FLAG_W = 3,
    parameter int DEPTH  = 4,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              flag_rst,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic [FLAG_W-1:0] flag_set,
    input  logic [FLAG_W-1:0] flag_clr,
    input  logic              flag_push,
    input  logic              flag_pop,
    output logic [FLAG_W-1:0] flag_out,
    output logic [SP_W-1:0]   flag_sp,
    output logic              flag_empty,
    output logic              flag_full,
    output logic              flag_err
);

    localparam logic [SP_W-1:0] c_SP_FULL = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] c_SP_ONE  = SP_W'(1);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              empty_q, full_q, err_q;
    logic [FLAG_W-1:0] stack_q [DEPTH];

    logic              w_push_req, w_pop_req, w_both;
    logic              w_push_ok, w_pop_ok, w_misuse;
    logic [FLAG_W-1:0] w_top;
    logic [FLAG_W-1:0] w_upd;

    // Simultaneous push and pop is treated as a misuse with no stack effect.
    assign w_push_req = flag_push & ~flag_pop;
    assign w_pop_req  = flag_pop & ~flag_push;
    assign w_both     = flag_push & flag_pop;
    assign w_push_ok  = w_push_req & ~full_q;
    assign w_pop_ok   = w_pop_req & ~empty_q;
    assign w_misuse   = (w_push_req & full_q) | (w_pop_req & empty_q) | w_both;

    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                w_top = stack_q[i];
            end
        end
    end

    // Lowest to highest priority: ALU write, set, clear, then restore.
    always_comb begin
        w_upd   = (flags_q & ~flag_we) | (flag_in & flag_we);
        w_upd   = w_upd | flag_set;
        w_upd   = w_upd & ~flag_clr;
        flags_d = w_pop_ok ? w_top : w_upd;
    end

    always_comb begin
        sp_d = sp_q;
        if (w_push_ok) begin
            sp_d = sp_q + c_SP_ONE;
        end else if (w_pop_ok) begin
            sp_d = sp_q - c_SP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (flag_rst) begin
            flags_q <= '0;
            sp_q    <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            empty_q <= (sp_d == '0);
            full_q  <= (sp_d == c_SP_FULL);
            err_q   <= err_q | w_misuse;
        end
    end

    // Stack storage holds no reset value; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!flag_rst && w_push_ok && (sp_q == SP_W'(i))) begin
                stack_q[i] <= flags_q;
            end
        end
    end

    assign flag_out   = flags_q;
    assign flag_sp    = sp_q;
    assign flag_empty = empty_q;
    assign flag_full  = full_q;
    assign flag_err   = err_q;

endmodule
`default_nettype wire
